seg7_capture: RTL and testbench
===============================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter NDIGIT, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter STABLE_CNT, default 3: consecutive identical samples required per digit, legal range 1..15.
REQ-003 SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_strobe, input, 1: sample enable, one sample taken per cycle with i_strobe=1.
REQ-006 SHALL have port i_seg7, input, 7: active-low segment pattern, bit0=a .. bit6=g.
REQ-007 SHALL have port i_an, input, NDIGIT: active-low digit select, bit k = digit k.
REQ-008 SHALL have port i_err_clr, input, 1: clears o_err.
REQ-009 SHALL have port o_bcd, output, 4*NDIGIT: committed digit values, nibble k = digit k.
REQ-010 SHALL have port o_digit_ok, output, NDIGIT: digit k has committed at least once since reset.
REQ-011 SHALL have port o_valid, output, 1: one-cycle frame-complete pulse.
REQ-012 SHALL have port o_err, output, 1: sticky invalid-pattern flag.

Function
REQ-013 SHALL decode patterns g..a as follows: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9. Any other pattern is invalid.
REQ-014 SHALL ignore a sample (no state change) when i_strobe=0, when i_an has no low bit, or when i_an has more than one low bit.
REQ-015 SHALL keep, per digit, a candidate value (4 bits) and a saturating stability counter (4 bits, saturates at STABLE_CNT).
REQ-016 SHALL load the candidate and set the counter to 1 on a valid sample for digit k that differs from candidate k; a valid sample equal to candidate k SHALL increment the counter.
REQ-017 SHALL write candidate k to o_bcd nibble k and set o_digit_ok[k] on the clock edge where counter k reaches STABLE_CNT, so the result is visible the cycle after the STABLE_CNT-th qualifying strobe. With STABLE_CNT=1, the first valid sample commits.
REQ-018 SHALL set frame-mask bit k on every valid sample that leaves counter k at STABLE_CNT, including samples taken while saturated.
REQ-019 SHALL pulse o_valid for exactly one cycle, registered, when the frame mask becomes all-ones, and SHALL clear the frame mask in the same cycle.
REQ-020 SHALL, on an invalid sample for digit k, set o_err, reset counter k to 0, and leave o_bcd unchanged.
REQ-021 SHALL clear o_err on i_err_clr=1; if an error and i_err_clr occur in the same cycle, set SHALL win.
REQ-022 SHALL implement frame assembly as an FSM. COLLECT moves to REPORT when the mask is full. REPORT asserts o_valid and returns to COLLECT unconditionally; a sample arriving in REPORT SHALL still be processed.

Reset
REQ-023 SHALL, while i_rst_n=0, asynchronously force o_bcd=0, o_digit_ok=0, o_valid=0, o_err=0, all candidates and counters to 0, the frame mask to 0, and the FSM to COLLECT.
REQ-024 SHALL discard any partial stability count or frame on reset mid-operation, with no o_valid after release until a full new frame completes.

Configuration
REQ-025 SHALL, when macro SEG7_CAPTURE_HEX_EN is defined, additionally decode 0001000=A(10), 0000011=b(11), 1000110=C(12), 0100001=d(13), 0000110=E(14), 0001110=F(15).
REQ-026 SHALL, when SEG7_CAPTURE_HEX_EN is undefined, treat those six patterns as invalid per REQ-020.

Verification
REQ-027 Scenario: NDIGIT=4, STABLE_CNT=3; scan digits 0..3 with patterns 1, 2, 3, 4, each three times -> o_bcd=16'h4321, o_digit_ok=4'hF, one o_valid pulse on the final commit.
REQ-028 Scenario: digit 0 sampled as 5, 5, 6, 6, 6 -> o_bcd[3:0] changes to 6 only after the fifth sample and never shows 5.
REQ-029 Scenario: i_an=4'b1100 or 4'b1111 with i_strobe=1 -> no change in candidates, counters, o_err or o_valid.
REQ-030 Scenario: pattern 0001000 on digit 2 -> o_err=1 with the macro undefined, or o_bcd[11:8]=4'hA after three samples with the macro defined; simultaneous error and i_err_clr -> o_err stays 1.
REQ-031 Scenario: assert i_rst_n=0 after two of three samples of a digit -> all outputs 0 immediately; after release, two more samples do not commit and a third does.
REQ-032 Scenario: static display rescanned continuously -> o_valid pulses once per complete scan of all four digits, each pulse one cycle wide.

Source files
------------

// File: rtl/seg7_capture_if.sv
// Sample/result bundle for seg7_capture: multiplexed segment sample inputs and
// committed-digit outputs. Names match the block's external pin names.
interface seg7_capture_if #(
    parameter int unsigned NDIGIT = 4
);
    logic                  i_strobe;
    logic [6:0]            i_seg7;
    logic [NDIGIT-1:0]     i_an;
    logic                  i_err_clr;
    logic [4*NDIGIT-1:0]   o_bcd;
    logic [NDIGIT-1:0]     o_digit_ok;
    logic                  o_valid;
    logic                  o_err;

    modport master (
        output i_strobe, i_seg7, i_an, i_err_clr,
        input  o_bcd, o_digit_ok, o_valid, o_err
    );

    modport slave (
        input  i_strobe, i_seg7, i_an, i_err_clr,
        output o_bcd, o_digit_ok, o_valid, o_err
    );
endinterface

// File: rtl/seg7_capture.sv
// Captures a multiplexed active-low 7-segment display into per-digit BCD values
// with stability filtering and frame-complete pulses. Define SEG7_CAPTURE_HEX_EN to also decode A..F.
module seg7_capture #(
    parameter int unsigned NDIGIT     = 4,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    seg7_capture_if.slave   bus
);

    localparam int unsigned VW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
    localparam logic [CW-1:0] SAT = CW'(STABLE_CNT);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    state_t                       state, state_nxt;
    logic [NDIGIT-1:0][VW-1:0]    cand_q, cand_nxt;
    logic [NDIGIT-1:0][CW-1:0]    cnt_q, cnt_nxt;
    logic [NDIGIT-1:0][VW-1:0]    bcd_q, bcd_nxt;
    logic [NDIGIT-1:0]            ok_q, ok_nxt;
    logic [NDIGIT-1:0]            mask_q, mask_nxt;
    logic                         valid_q, valid_nxt;
    logic                         err_q, err_nxt;

    logic [NDIGIT-1:0]            sel;
    logic                         one_hot;
    logic [IW-1:0]                idx;
    logic                         sample_ok;
    logic [VW:0]                  dec;
    logic [CW-1:0]                cnt_new;
    logic                         err_set;

    // Returns {legal, value}; illegal patterns come back with legal=0.
    function automatic logic [VW:0] decode(input logic [6:0] s);
        logic [VW:0] r;
        r = '0;
        case (s)
            7'b1000000: r = {1'b1, 4'd0};
            7'b1111001: r = {1'b1, 4'd1};
            7'b0100100: r = {1'b1, 4'd2};
            7'b0110000: r = {1'b1, 4'd3};
            7'b0011001: r = {1'b1, 4'd4};
            7'b0010010: r = {1'b1, 4'd5};
            7'b0000010: r = {1'b1, 4'd6};
            7'b1111000: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0010000: r = {1'b1, 4'd9};
`ifdef SEG7_CAPTURE_HEX_EN
            7'b0001000: r = {1'b1, 4'd10};
            7'b0000011: r = {1'b1, 4'd11};
            7'b1000110: r = {1'b1, 4'd12};
            7'b0100001: r = {1'b1, 4'd13};
            7'b0000110: r = {1'b1, 4'd14};
            7'b0001110: r = {1'b1, 4'd15};
`else
`endif
            default:    r = '0;
        endcase
        return r;
    endfunction

    // Digit select must have exactly one low bit for the sample to count.
    always_comb begin
        sel     = ~bus.i_an;
        one_hot = (sel != '0) && ((sel & (sel - NDIGIT'(1))) == '0);
        idx     = '0;
        for (int unsigned k = 0; k < NDIGIT; k++) begin
            if (sel[k]) begin
                idx = IW'(k);
            end
        end
        sample_ok = bus.i_strobe && one_hot;
        dec       = decode(bus.i_seg7);
    end

    // Per-digit stability filter, commit, error flag and frame FSM.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand_q;
        cnt_nxt   = cnt_q;
        bcd_nxt   = bcd_q;
        ok_nxt    = ok_q;
        mask_nxt  = mask_q;
        valid_nxt = 1'b0;
        err_set   = 1'b0;
        cnt_new   = '0;

        if (sample_ok) begin
            if (!dec[VW]) begin
                err_set      = 1'b1;
                cnt_nxt[idx] = '0;
            end else begin
                if (dec[VW-1:0] != cand_q[idx]) begin
                    cand_nxt[idx] = dec[VW-1:0];
                    cnt_new       = CW'(1);
                end else if (cnt_q[idx] < SAT) begin
                    cnt_new       = CW'(cnt_q[idx] + CW'(1));
                end else begin
                    cnt_new       = cnt_q[idx];
                end
                cnt_nxt[idx] = cnt_new;
                // Saturated samples re-commit the same value and keep feeding the frame mask.
                if (cnt_new == SAT) begin
                    bcd_nxt[idx]  = dec[VW-1:0];
                    ok_nxt[idx]   = 1'b1;
                    mask_nxt[idx] = 1'b1;
                end
            end
        end

        if (err_set) begin
            err_nxt = 1'b1;
        end else if (bus.i_err_clr) begin
            err_nxt = 1'b0;
        end else begin
            err_nxt = err_q;
        end

        case (state)
            COLLECT: begin
                if (&mask_nxt) begin
                    state_nxt = REPORT;
                    valid_nxt = 1'b1;
                    mask_nxt  = '0;
                end
            end
            REPORT: begin
                state_nxt = COLLECT;
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= COLLECT;
            cand_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ok_q    <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cand_q  <= cand_nxt;
            cnt_q   <= cnt_nxt;
            bcd_q   <= bcd_nxt;
            ok_q    <= ok_nxt;
            mask_q  <= mask_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
        end
    end

    assign bus.o_bcd      = bcd_q;
    assign bus.o_digit_ok = ok_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_err      = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus randomized
// scanning, compared every cycle against a behavioural model of the decoder.
module tb_seg7_capture;

    localparam int ND = 4;
    localparam int SC = 3;

    logic clk;
    logic rst_n;

    seg7_capture_if #(.NDIGIT(ND)) bus ();

    seg7_capture #(.NDIGIT(ND), .STABLE_CNT(SC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Segment pattern (g..a) for a digit value 0..15.
    function automatic logic [6:0] pat(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Model decode: search the pattern table; -1 means illegal.
    function automatic int mdec(input logic [6:0] s);
        int top;
`ifdef SEG7_CAPTURE_HEX_EN
        top = 15;
`else
        top = 9;
`endif
        for (int d = 0; d <= top; d++) begin
            if (pat(d) == s) return d;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    endtask

    // Behavioural model state
    int         m_cand [ND];
    int         m_cnt  [ND];
    logic [15:0] m_bcd;
    logic [3:0]  m_ok;
    logic [3:0]  m_mask;
    logic        m_valid;
    logic        m_err;
    int          m_sel, m_nz, m_d;
    bit          m_eset;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ND; k++) begin
                m_cand[k] = 0;
                m_cnt[k]  = 0;
            end
            m_bcd = '0; m_ok = '0; m_mask = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_nz = 0; m_sel = 0; m_eset = 0;
            for (int k = 0; k < ND; k++) begin
                if (!bus.i_an[k]) begin
                    m_nz++;
                    m_sel = k;
                end
            end
            if (bus.i_strobe && m_nz == 1) begin
                m_d = mdec(bus.i_seg7);
                if (m_d < 0) begin
                    m_eset = 1;
                    m_cnt[m_sel] = 0;
                end else begin
                    if (m_d != m_cand[m_sel]) begin
                        m_cand[m_sel] = m_d;
                        m_cnt[m_sel]  = 1;
                    end else if (m_cnt[m_sel] < SC) begin
                        m_cnt[m_sel]++;
                    end
                    if (m_cnt[m_sel] == SC) begin
                        m_bcd[m_sel*4 +: 4] = 4'(m_cand[m_sel]);
                        m_ok[m_sel]   = 1'b1;
                        m_mask[m_sel] = 1'b1;
                    end
                end
            end
            if (m_eset) m_err = 1'b1;
            else if (bus.i_err_clr) m_err = 1'b0;
            // A full frame is reported once; the report cycle cannot itself report.
            if (!m_valid && m_mask == 4'hF) begin
                m_valid = 1'b1;
                m_mask  = '0;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("bcd",      32'(bus.o_bcd),      32'(m_bcd));
        chk("digit_ok", 32'(bus.o_digit_ok), 32'(m_ok));
        chk("valid",    32'(bus.o_valid),    32'(m_valid));
        chk("err",      32'(bus.o_err),      32'(m_err));
    end

    // Pulse counting and digit-0 glitch monitor
    int   vcount = 0;
    int   dbl    = 0;
    logic prev_v = 1'b0;
    bit   mon5   = 0;
    int   seen5  = 0;
    always @(negedge clk) begin
        if (bus.o_valid) vcount++;
        if (bus.o_valid && prev_v) dbl++;
        prev_v = bus.o_valid;
        if (mon5 && bus.o_bcd[3:0] == 4'd5) seen5++;
    end

    task automatic step(input bit s, input logic [6:0] seg, input logic [3:0] an, input bit clr);
        @(negedge clk);
        bus.i_strobe  = s;
        bus.i_seg7    = seg;
        bus.i_an      = an;
        bus.i_err_clr = clr;
        @(posedge clk);
        #1;
        bus.i_strobe  = 1'b0;
        bus.i_err_clr = 1'b0;
    endtask

    function automatic logic [3:0] an_of(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << k);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int vstart;
    int vals [4];
    int intent [4];
    int k, r;
    logic [3:0] an_r;
    logic [6:0] seg_r;
    logic [15:0] bsave;

    initial begin
        bus.i_strobe = 1'b0; bus.i_seg7 = 7'h7F; bus.i_an = 4'hF; bus.i_err_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bcd", 32'(bus.o_bcd), 32'h0);
        chk("rst_ok",  32'(bus.o_digit_ok), 32'h0);
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_err", 32'(bus.o_err), 32'h0);
        rst_n = 1'b1;

        // Scan digits 0..3 with 1,2,3,4 three rounds
        vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
        vstart = vcount;
        for (int rr = 0; rr < 3; rr++)
            for (int d = 0; d < 4; d++)
                step(1, pat(vals[d]), an_of(d), 0);
        chk("scan_bcd", 32'(bus.o_bcd), 32'h4321);
        chk("scan_ok", 32'(bus.o_digit_ok), 32'hF);
        chk("scan_valid", 32'(bus.o_valid), 32'h1);
        step(0, 7'h7F, 4'hF, 0);
        step(0, 7'h7F, 4'hF, 0);
        chk("scan_pulses", 32'(vcount - vstart), 32'd1);

        // Digit 0: 5,5,6,6,6 must never show 5
        mon5 = 1;
        step(1, pat(5), an_of(0), 0);
        step(1, pat(5), an_of(0), 0);
        step(1, pat(6), an_of(0), 0);
        step(1, pat(6), an_of(0), 0);
        chk("d0_hold", 32'(bus.o_bcd[3:0]), 32'd1);
        step(1, pat(6), an_of(0), 0);
        chk("d0_commit", 32'(bus.o_bcd[3:0]), 32'd6);
        step(0, 7'h7F, 4'hF, 0);
        mon5 = 0;
        chk("d0_no5", 32'(seen5), 32'd0);

        // Ambiguous or absent digit select is ignored
        bsave = bus.o_bcd;
        step(1, 7'h7F,  4'b1100, 0);
        step(1, 7'h7F,  4'b1111, 0);
        step(1, pat(9), 4'b1100, 0);
        chk("an_err", 32'(bus.o_err), 32'd0);
        chk("an_bcd", 32'(bus.o_bcd), 32'(bsave));
        chk("an_valid", 32'(bus.o_valid), 32'd0);

        // Hex pattern A on digit 2
        for (int i = 0; i < 3; i++) step(1, 7'b0001000, an_of(2), 0);
`ifdef SEG7_CAPTURE_HEX_EN
        chk("hexA_bcd", 32'(bus.o_bcd[11:8]), 32'hA);
        chk("hexA_err", 32'(bus.o_err), 32'd0);
`else
        chk("hexA_err", 32'(bus.o_err), 32'd1);
        chk("hexA_bcd", 32'(bus.o_bcd[11:8]), 32'h3);
`endif
        step(1, 7'h7F, an_of(2), 1);
        chk("err_set_wins", 32'(bus.o_err), 32'd1);
        step(0, 7'h7F, 4'hF, 1);
        chk("err_clr", 32'(bus.o_err), 32'd0);

        // Reset mid-count discards partial stability
        step(1, pat(7), an_of(1), 0);
        step(1, pat(7), an_of(1), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_bcd", 32'(bus.o_bcd), 32'h0);
        chk("mrst_ok",  32'(bus.o_digit_ok), 32'h0);
        chk("mrst_err_valid", 32'({bus.o_err, bus.o_valid}), 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        vstart = vcount;
        step(1, pat(7), an_of(1), 0);
        step(1, pat(7), an_of(1), 0);
        chk("mrst_nocommit", 32'({bus.o_digit_ok, bus.o_bcd[7:4]}), 32'h00);
        step(1, pat(7), an_of(1), 0);
        chk("mrst_commit", 32'({bus.o_digit_ok, bus.o_bcd[7:4]}), 32'h27);
        chk("mrst_novalid", 32'(vcount - vstart), 32'd0);

        // Static display rescanned continuously
        do_reset();
        vals[0] = 8; vals[1] = 9; vals[2] = 0; vals[3] = 5;
        vstart = vcount; dbl = 0;
        for (int rr = 0; rr < 12; rr++)
            for (int d = 0; d < 4; d++)
                step(1, pat(vals[d]), an_of(d), 0);
        step(0, 7'h7F, 4'hF, 0);
        step(0, 7'h7F, 4'hF, 0);
        chk("rescan_pulses", 32'(vcount - vstart), 32'd10);
        chk("rescan_width", 32'(dbl), 32'd0);
        chk("rescan_bcd", 32'(bus.o_bcd), 32'h5098);

        // Randomized scanning checked by the per-cycle model compare
        for (int d = 0; d < 4; d++) intent[d] = $urandom_range(0, 15);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 3);
            if (r < 8) an_r = an_of(k);
            else an_r = 4'($urandom);
            if ($urandom_range(0, 15) == 0) intent[k] = $urandom_range(0, 15);
            if ($urandom_range(0, 99) < 85) seg_r = pat(intent[k]);
            else seg_r = 7'($urandom);
            step($urandom_range(0, 7) != 0, seg_r, an_r, $urandom_range(0, 19) == 0);
            if (n == 1500) do_reset();
        end
        step(0, 7'h7F, 4'hF, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
